alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Round-robin arbiter and sequencer that shares one combinational 32-bit ALU (functs ADD..SRL) between two requesters. Each request is accepted with a valid/ready handshake. Its operands are registered into the ALU, the result is captured after one execute cycle, and a tagged response is returned on a single valid/ready response port. The block sits between two operation sources, such as a switch/button front end and a test sequencer, and the shared ALU instance.

## Interface
Parameters:
- WIDTH, 32, operand and result width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle when high with valid.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_shamt  in  5  requester 0 shift amount.
- req0_funct  in  4  requester 0 op code: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, SLA=6, SRA=7, SRL=8.
- req1_valid, req1_ready, req1_a, req1_b, req1_shamt, req1_funct  same widths and meanings for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the response.
- rsp_result  out  WIDTH  captured ALU result.
- rsp_err  out  1  illegal funct (greater than 8).
- alu_a, alu_b  out  WIDTH  registered operands to the shared ALU.
- alu_shamt  out  5  registered shift amount.
- alu_funct  out  4  registered op code.
- alu_out  in  WIDTH  combinational ALU result.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitration is combinational over req0_valid and req1_valid.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester indicated by the priority pointer `prio` is granted.
  - The granted requester's ready is high in the same cycle; the other ready is low.
  - Both readies are low in EXEC and RESP.
- Accept, on the edge where valid & ready:
  - Latch a, b, shamt and funct into the alu_* registers.
  - Latch the requester index into rsp_id.
  - Set `prio` to the other requester.
  - If funct is 0..8, go to EXEC.
  - If funct is greater than 8, go to RESP with rsp_err=1 and rsp_result=0; the ALU result is not captured.
- EXEC: one cycle. At its end, rsp_result <= alu_out, rsp_err <= 0, and the FSM goes to RESP.
- RESP:
  - rsp_valid=1.
  - rsp_id, rsp_result and rsp_err are held stable until rsp_ready=1.
  - On that edge, rsp_valid <= 0 and the FSM goes to IDLE.
- alu_* registers hold their last value outside accept edges; the ALU input does not toggle while idle.
- Priority pointer: after reset it favours req0. It changes only on accept, never on idle cycles.
- Arithmetic: the ALU computes modulo 2^WIDTH. The arbiter never inspects or modifies alu_out.

## Timing
- Reset (synchronous; wins over every other condition on the same edge):
  - State=IDLE, prio=req0.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_shamt=0, alu_funct=0.
  - busy=0.
  - req0_ready and req1_ready follow IDLE arbitration only from the cycle after reset deasserts; they are low while rst=1.
- Latency, legal funct:
  - Accept at edge N.
  - alu_* valid after N.
  - Result captured at N+1.
  - rsp_valid high after N+1.
- Latency, illegal funct: rsp_valid high after edge N (one cycle earlier than a legal op).
- Throughput: minimum 3 cycles per legal op (accept, EXEC, RESP with rsp_ready=1, back in IDLE). A new accept is possible in the first IDLE cycle.
- Backpressure: RESP may last any number of cycles. Outputs are stable throughout, and no request is accepted.
- Reset mid-operation, in EXEC or RESP: the in-flight op is dropped with no response, and prio returns to req0.
- A requester deasserting valid while not granted is legal; it loses nothing.

## Test plan
1. SUB after reset:
   - Stimulus: req0 only, a=200, b=100, funct=1.
   - Response: req0_ready=1 in the same cycle, rsp_valid two edges after accept, rsp_id=0, rsp_result=100, rsp_err=0.
2. SUB with wraparound:
   - Stimulus: req1 only, a=100, b=200, funct=1.
   - Response: rsp_id=1, rsp_result=0xFFFFFF9C.
3. SRA:
   - Stimulus: req1 a=0x80000000, shamt=4, funct=7.
   - Response: rsp_result=0xF8000000.
4. Round-robin fairness:
   - Stimulus: both valid from reset and held, req0 ADD 1+2, req1 XOR 0xF0F0^0x0FF0; rsp_ready=1.
   - Response: responses alternate id0 (3), id1 (0xFF00), id0 (3), and so on; a third accept never goes to the same requester twice in a row.
5. Backpressure:
   - Stimulus: rsp_ready=0 for 5 cycles while in RESP, with both requesters valid.
   - Response: rsp_* stable, both readies low, busy=1. After rsp_ready=1, the FSM returns to IDLE and the next grant goes to the other requester.
6. Illegal funct and reset mid-operation:
   - Stimulus A: funct=9.
   - Response A: rsp_valid one edge after accept, rsp_err=1, rsp_result=0.
   - Stimulus B: rst=1 during EXEC.
   - Response B: next cycle rsp_valid=0, alu_*=0, no response emitted; the first post-reset grant with both valid goes to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer in front of one shared
// combinational ALU. Two requesters compete for the ALU. The winner's
// operands are registered onto alu_*. The result is captured after one
// execute cycle and returned as a tagged response on a single valid/ready
// port.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   reqN_valid/ready    request handshake, N = 0,1
//   reqN_a/b/shamt/funct request operands and op code (0..8 legal)
//   rsp_valid/ready     response handshake
//   rsp_id/result/err   responding requester, captured result, illegal-op flag
//   alu_a/b/shamt/funct registered operands driven to the shared ALU
//   alu_out             combinational result returned by the shared ALU
//   busy                high whenever the sequencer is not idle
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [4:0]       req0_shamt,
  input  logic [3:0]       req0_funct,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [4:0]       req1_shamt,
  input  logic [3:0]       req1_funct,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_shamt,
  output logic [3:0]       alu_funct,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       shamt;
    logic [3:0]       funct;
  } req_t;

  state_t state, state_nxt;
  logic   prio;      // requester favoured when both are valid
  logic   grant;     // index of the requester that wins this cycle
  logic   accept;
  logic   illegal;
  req_t   sel;

  // Arbitration and next-state logic. Readies are held low during reset so
  // nothing can be accepted on the reset edge.
  always_comb begin
    grant      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_nxt  = state;
    if (req0_valid && req1_valid) grant = prio;
    else                          grant = req1_valid;
    if (state == IDLE && !rst) begin
      req0_ready = req0_valid && !grant;
      req1_ready = req1_valid &&  grant;
    end
    accept  = (req0_ready && req0_valid) || (req1_ready && req1_valid);
    sel     = grant ? '{req1_a, req1_b, req1_shamt, req1_funct}
                    : '{req0_a, req0_b, req0_shamt, req0_funct};
    illegal = sel.funct > 4'd8;
    case (state)
      IDLE:    if (accept) state_nxt = illegal ? RESP : EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_shamt  <= '0;
      alu_funct  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a     <= sel.a;
        alu_b     <= sel.b;
        alu_shamt <= sel.shamt;
        alu_funct <= sel.funct;
        rsp_id    <= grant;
        prio      <= ~grant;
        // An illegal op skips EXEC, so its response fields are set here.
        if (illegal) begin
          rsp_result <= '0;
          rsp_err    <= 1'b1;
        end
      end
      if (state == EXEC) begin
        rsp_result <= alu_out;
        rsp_err    <= 1'b0;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. A behavioural ALU stands in for the
// shared ALU, and every expected value is a hand-computed constant.
module tb_alu_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]   req0_shamt, req1_shamt;
  logic [3:0]   req0_funct, req1_funct;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [W-1:0] rsp_result, alu_a, alu_b, alu_out;
  logic [4:0]   alu_shamt;
  logic [3:0]   alu_funct;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt), .req0_funct(req0_funct),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt), .req1_funct(req1_funct),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
    .alu_out(alu_out), .busy(busy)
  );

  // Shared ALU model.
  always_comb begin
    alu_out = '0;
    case (alu_funct)
      4'd0: alu_out = alu_a + alu_b;
      4'd1: alu_out = alu_a - alu_b;
      4'd2: alu_out = alu_a & alu_b;
      4'd3: alu_out = alu_a | alu_b;
      4'd4: alu_out = alu_a ^ alu_b;
      4'd5: alu_out = ~alu_a;
      4'd6: alu_out = alu_a << alu_shamt;
      4'd7: alu_out = $signed(alu_a) >>> alu_shamt;
      4'd8: alu_out = alu_a >> alu_shamt;
      default: alu_out = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] sh, input logic [3:0] f);
    req0_valid = v; req0_a = a; req0_b = b; req0_shamt = sh; req0_funct = f;
  endtask

  task automatic set1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [4:0] sh, input logic [3:0] f);
    req1_valid = v; req1_a = a; req1_b = b; req1_shamt = sh; req1_funct = f;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    set0(1'b1, 32'd200, 32'd100, 5'd0, 4'd1);
    set1(1'b0, '0, '0, 5'd0, 4'd0);
    tick(); tick();
    // Reset state
    settle();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_rsp_result", rsp_result, 0);
    rst = 1'b0;
    settle();

    // 1: SUB 200-100 from req0
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    settle();
    chk("t1_exec_busy", busy, 1);
    chk("t1_exec_rsp_valid", rsp_valid, 0);
    chk("t1_alu_a", alu_a, 200);
    chk("t1_alu_funct", alu_funct, 1);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_result", rsp_result, 100);
    chk("t1_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    chk("t1_idle_rsp_valid", rsp_valid, 0);
    chk("t1_idle_busy", busy, 0);

    // 2: SUB wraparound from req1
    set1(1'b1, 32'd100, 32'd200, 5'd0, 4'd1);
    settle();
    chk("t2_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("t2_rsp_id", rsp_id, 1);
    chk("t2_rsp_result", rsp_result, 32'hFFFF_FF9C);
    tick();

    // 3: SRA
    set1(1'b1, 32'h8000_0000, 32'd0, 5'd4, 4'd7);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("t3_rsp_result", rsp_result, 32'hF800_0000);
    chk("t3_rsp_id", rsp_id, 1);
    tick();

    // 4: round-robin with both valid from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set0(1'b1, 32'd1, 32'd2, 5'd0, 4'd0);
    set1(1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0, 4'd4);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t4_ready0", req0_ready, (i % 2 == 0));
      chk("t4_ready1", req1_ready, (i % 2 == 1));
      tick(); tick();
      chk("t4_rsp_id", rsp_id, (i % 2));
      chk("t4_rsp_result", rsp_result, (i % 2 == 0) ? 32'd3 : 32'h0000_FF00);
      tick();
    end

    // 5: backpressure with both valid; req0 is favoured next
    rsp_ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t5_rsp_valid", rsp_valid, 1);
      chk("t5_rsp_id", rsp_id, 0);
      chk("t5_rsp_result", rsp_result, 3);
      chk("t5_ready0", req0_ready, 0);
      chk("t5_ready1", req1_ready, 0);
      chk("t5_busy", busy, 1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    settle();
    chk("t5_idle_busy", busy, 0);
    chk("t5_next_ready0", req0_ready, 0);
    chk("t5_next_ready1", req1_ready, 1);
    tick(); tick();
    chk("t5_next_rsp_id", rsp_id, 1);
    chk("t5_next_rsp_result", rsp_result, 32'h0000_FF00);
    tick();

    // 6A: illegal funct, response one edge after accept
    req1_valid = 1'b0;
    set0(1'b1, 32'd7, 32'd8, 5'd0, 4'd9);
    tick();
    req0_valid = 1'b0;
    settle();
    chk("t6a_rsp_valid", rsp_valid, 1);
    chk("t6a_rsp_err", rsp_err, 1);
    chk("t6a_rsp_result", rsp_result, 0);
    chk("t6a_alu_funct", alu_funct, 9);
    tick();
    chk("t6a_idle", busy, 0);

    // 6B: reset during EXEC drops the op; prio returns to req0
    set0(1'b1, 32'd5, 32'd6, 5'd0, 4'd0);
    tick();
    req0_valid = 1'b0;
    settle();
    chk("t6b_exec_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("t6b_rsp_valid", rsp_valid, 0);
    chk("t6b_alu_a", alu_a, 0);
    chk("t6b_alu_funct", alu_funct, 0);
    chk("t6b_busy", busy, 0);
    rst = 1'b0;
    set0(1'b1, 32'd5, 32'd6, 5'd0, 4'd0);
    set1(1'b1, 32'd1, 32'd1, 5'd0, 4'd0);
    settle();
    chk("t6b_ready0", req0_ready, 1);
    chk("t6b_ready1", req1_ready, 0);
    tick();
    chk("t6b_exec_rsp_valid", rsp_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
